// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bundle: issue handshake, register-file ports, writeback and
// execute-side output. The slave modport is the stage's view; master is the surrounding pipeline.
interface operand_fetch_if #(
  parameter int REG_WIDTH = 8,
  parameter int REG_COUNT = 8
);
  localparam int AW = $clog2(REG_COUNT);

  logic                 in_valid;
  logic                 in_ready;
  logic [AW-1:0]        in_src1;
  logic [AW-1:0]        in_src2;
  logic [AW-1:0]        in_dst;
  logic                 in_wen;

  logic [AW-1:0]        rf_rd_addr1;
  logic [AW-1:0]        rf_rd_addr2;
  logic [REG_WIDTH-1:0] rf_rd_data1;
  logic [REG_WIDTH-1:0] rf_rd_data2;
  logic                 rf_we;
  logic [AW-1:0]        rf_wr_addr;
  logic [REG_WIDTH-1:0] rf_wr_data;

  logic                 wb_valid;
  logic [AW-1:0]        wb_addr;
  logic [REG_WIDTH-1:0] wb_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] out_op1;
  logic [REG_WIDTH-1:0] out_op2;
  logic [AW-1:0]        out_dst;
  logic                 out_wen;
  logic                 wb_err;

  modport slave (
    input  in_valid, in_src1, in_src2, in_dst, in_wen,
    input  rf_rd_data1, rf_rd_data2,
    input  wb_valid, wb_addr, wb_data,
    input  out_ready,
    output in_ready,
    output rf_rd_addr1, rf_rd_addr2, rf_we, rf_wr_addr, rf_wr_data,
    output out_valid, out_op1, out_op2, out_dst, out_wen, wb_err
  );

  modport master (
    output in_valid, in_src1, in_src2, in_dst, in_wen,
    output rf_rd_data1, rf_rd_data2,
    output wb_valid, wb_addr, wb_data,
    output out_ready,
    input  in_ready,
    input  rf_rd_addr1, rf_rd_addr2, rf_we, rf_wr_addr, rf_wr_data,
    input  out_valid, out_op1, out_op2, out_dst, out_wen, wb_err
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch / writeback stage: reads the register file, bypasses in-flight writebacks,
// stalls on RAW/WAW through a per-register pending scoreboard, buffers writebacks one cycle.
module operand_fetch #(
  parameter int REG_WIDTH = 8,
  parameter int REG_COUNT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_fetch_if.slave  bus
);
  localparam int AW = $clog2(REG_COUNT);

  logic [REG_COUNT-1:0] pending_q, pending_d;
  logic [REG_COUNT-1:0] clr_vec, set_vec;
  logic                 wbuf_valid_q, wbuf_valid_d;
  logic [AW-1:0]        wbuf_addr_q, wbuf_addr_d;
  logic [REG_WIDTH-1:0] wbuf_data_q, wbuf_data_d;
  logic                 out_valid_q, out_valid_d;
  logic [REG_WIDTH-1:0] out_op1_q, out_op1_d;
  logic [REG_WIDTH-1:0] out_op2_q, out_op2_d;
  logic [AW-1:0]        out_dst_q, out_dst_d;
  logic                 out_wen_q, out_wen_d;
  logic                 wb_err_q, wb_err_d;
  logic                 hazard, in_ready, accept;

  // Newest value wins: the writeback arriving this cycle, then the buffered one, then the RF.
  function automatic logic [REG_WIDTH-1:0] sel_op(
    input logic [AW-1:0]        src,
    input logic [REG_WIDTH-1:0] rf_data,
    input logic                 wb_v,
    input logic [AW-1:0]        wb_a,
    input logic [REG_WIDTH-1:0] wb_d,
    input logic                 buf_v,
    input logic [AW-1:0]        buf_a,
    input logic [REG_WIDTH-1:0] buf_d
  );
    if (wb_v && wb_a == src)        return wb_d;
    else if (buf_v && buf_a == src) return buf_d;
    else                            return rf_data;
  endfunction

  always_comb begin
    clr_vec = '0;
    for (int r = 0; r < REG_COUNT; r++)
      clr_vec[r] = bus.wb_valid && (bus.wb_addr == AW'(r));
  end

  assign hazard = (pending_q[bus.in_src1] && !clr_vec[bus.in_src1]) ||
                  (pending_q[bus.in_src2] && !clr_vec[bus.in_src2]) ||
                  (bus.in_wen && pending_q[bus.in_dst] && !clr_vec[bus.in_dst]);
  assign in_ready = rst_n && !hazard && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    set_vec = '0;
    for (int r = 0; r < REG_COUNT; r++)
      set_vec[r] = accept && bus.in_wen && (bus.in_dst == AW'(r));
  end

  // A re-issue to a register in its own writeback cycle must leave it pending.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  always_comb begin
    wbuf_valid_d = bus.wb_valid;
    wbuf_addr_d  = bus.wb_valid ? bus.wb_addr : wbuf_addr_q;
    wbuf_data_d  = bus.wb_valid ? bus.wb_data : wbuf_data_q;
    wb_err_d     = wb_err_q | (bus.wb_valid && !pending_q[bus.wb_addr]);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_dst_d   = out_dst_q;
    out_wen_d   = out_wen_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_op1_d   = sel_op(bus.in_src1, bus.rf_rd_data1, bus.wb_valid, bus.wb_addr,
                           bus.wb_data, wbuf_valid_q, wbuf_addr_q, wbuf_data_q);
      out_op2_d   = sel_op(bus.in_src2, bus.rf_rd_data2, bus.wb_valid, bus.wb_addr,
                           bus.wb_data, wbuf_valid_q, wbuf_addr_q, wbuf_data_q);
      out_dst_d   = bus.in_dst;
      out_wen_d   = bus.in_wen;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q    <= '0;
      wbuf_valid_q <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_op1_q    <= '0;
      out_op2_q    <= '0;
      out_dst_q    <= '0;
      out_wen_q    <= 1'b0;
      wb_err_q     <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_data_q  <= wbuf_data_d;
      out_valid_q  <= out_valid_d;
      out_op1_q    <= out_op1_d;
      out_op2_q    <= out_op2_d;
      out_dst_q    <= out_dst_d;
      out_wen_q    <= out_wen_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.rf_rd_addr1 = bus.in_src1;
  assign bus.rf_rd_addr2 = bus.in_src2;
  assign bus.rf_we       = wbuf_valid_q;
  assign bus.rf_wr_addr  = wbuf_addr_q;
  assign bus.rf_wr_data  = wbuf_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op1     = out_op1_q;
  assign bus.out_op2     = out_op2_q;
  assign bus.out_dst     = out_dst_q;
  assign bus.out_wen     = out_wen_q;
  assign bus.wb_err      = wb_err_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal expectations, then random traffic
// compared every cycle against an architectural-value / pending-set model.
module tb_operand_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  operand_fetch_if #(.REG_WIDTH(8), .REG_COUNT(8)) bus ();
  operand_fetch #(.REG_WIDTH(8), .REG_COUNT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Register file owned by the bench, written only through the stage's write port.
  logic [7:0] rf_mem [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
  assign bus.rf_rd_data1 = rf_mem[bus.rf_rd_addr1];
  assign bus.rf_rd_data2 = rf_mem[bus.rf_rd_addr2];
  always @(posedge clk) if (bus.rf_we) rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;

  // Model: newest architectural value per register, set of registers awaiting writeback,
  // the expected output register, the expected write-port contents and the error flag.
  logic [7:0] arch [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
  bit         pend [8];
  bit         eo_valid, eo_wen, ewb_v, eerr;
  logic [7:0] eo_op1, eo_op2, ewb_d;
  logic [2:0] eo_dst, ewb_a;
  bit         last_wbv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit rstn, input bit iv, input logic [2:0] s1, input logic [2:0] s2,
                      input logic [2:0] d, input bit wen, input bit ordy, input bit wbv,
                      input logic [2:0] wba, input logic [7:0] wbd, output bit rdy);
    bit         haz, exp_rdy, acc;
    logic [7:0] v1, v2;
    @(negedge clk);
    rst_n         = rstn;
    bus.in_valid  = iv;
    bus.in_src1   = s1;
    bus.in_src2   = s2;
    bus.in_dst    = d;
    bus.in_wen    = wen;
    bus.out_ready = ordy;
    bus.wb_valid  = wbv;
    bus.wb_addr   = wba;
    bus.wb_data   = wbd;
    #1;
    v1  = (wbv && wba == s1) ? wbd : arch[s1];
    v2  = (wbv && wba == s2) ? wbd : arch[s2];
    haz = (pend[s1] && !(wbv && wba == s1)) || (pend[s2] && !(wbv && wba == s2)) ||
          (wen && pend[d] && !(wbv && wba == d));
    exp_rdy = rstn && !haz && (!eo_valid || ordy);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("rf_rd_addr1", bus.rf_rd_addr1, s1);
    chk("rf_rd_addr2", bus.rf_rd_addr2, s2);
    chk("out_valid", bus.out_valid, eo_valid);
    if (eo_valid) begin
      chk("out_op1", bus.out_op1, eo_op1);
      chk("out_op2", bus.out_op2, eo_op2);
      chk("out_dst", bus.out_dst, eo_dst);
      chk("out_wen", bus.out_wen, eo_wen);
    end
    chk("rf_we", bus.rf_we, ewb_v);
    if (ewb_v) begin
      chk("rf_wr_addr", bus.rf_wr_addr, ewb_a);
      chk("rf_wr_data", bus.rf_wr_data, ewb_d);
    end
    chk("wb_err", bus.wb_err, eerr);
    rdy = bus.in_ready;
    @(posedge clk);
    if (!rstn) begin
      foreach (pend[i]) pend[i] = 1'b0;
      eo_valid = 0; eo_wen = 0; eo_op1 = 0; eo_op2 = 0; eo_dst = 0;
      ewb_v = 0; ewb_a = 0; ewb_d = 0; eerr = 0;
    end else begin
      acc = iv && exp_rdy;
      if (acc) begin
        eo_valid = 1; eo_op1 = v1; eo_op2 = v2; eo_dst = d; eo_wen = wen;
      end else if (ordy) begin
        eo_valid = 0;
      end
      if (wbv && !pend[wba]) eerr = 1;
      if (wbv) begin
        pend[wba] = 1'b0;
        arch[wba] = wbd;
        ewb_a = wba;
        ewb_d = wbd;
      end
      ewb_v = wbv;
      if (acc && wen) pend[d] = 1'b1;
    end
    last_wbv = wbv;
    #1;
  endtask

  task automatic rand_step(input bit allow_err);
    bit         r, wbv;
    logic [2:0] wba, list [$];
    list.delete();
    for (int i = 0; i < 8; i++) if (pend[i]) list.push_back(3'(i));
    wbv = 0;
    wba = 3'($urandom_range(7));
    if (list.size() > 0 && $urandom_range(99) < 40) begin
      wbv = 1;
      wba = list[$urandom_range(list.size() - 1)];
    end else if (allow_err && $urandom_range(99) < 3) begin
      wbv = 1;
    end
    step(1'b1, $urandom_range(99) < 70, 3'($urandom_range(7)), 3'($urandom_range(7)),
         3'($urandom_range(7)), $urandom_range(1) == 1, $urandom_range(99) < 75,
         wbv, wba, 8'($urandom_range(255)), r);
  endtask

  initial begin
    bit r;
    rst_n = 0;
    bus.in_valid = 0; bus.in_src1 = 0; bus.in_src2 = 0; bus.in_dst = 0; bus.in_wen = 0;
    bus.out_ready = 0; bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0;

    // reset
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, r);
    step(0, 1, 1, 2, 0, 0, 1, 0, 0, 0, r);
    chk("rst_in_ready", r, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_op1", bus.out_op1, 0);
    chk("rst_out_op2", bus.out_op2, 0);
    chk("rst_out_dst", bus.out_dst, 0);
    chk("rst_out_wen", bus.out_wen, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_rf_wr_addr", bus.rf_wr_addr, 0);
    chk("rst_rf_wr_data", bus.rf_wr_data, 0);
    chk("rst_wb_err", bus.wb_err, 0);

    // basic read
    step(1, 1, 1, 2, 0, 0, 1, 0, 0, 0, r);
    chk("basic_ready", r, 1);
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_op1", bus.out_op1, 8'h11);
    chk("basic_op2", bus.out_op2, 8'h22);

    // RAW through the writeback bypass
    step(1, 1, 0, 0, 3, 1, 1, 0, 0, 0, r);
    step(1, 1, 3, 0, 0, 0, 1, 0, 0, 0, r);
    chk("raw_stall1", r, 0);
    step(1, 1, 3, 0, 0, 0, 1, 0, 0, 0, r);
    chk("raw_stall2", r, 0);
    step(1, 1, 3, 0, 0, 0, 1, 1, 3, 8'hA5, r);
    chk("raw_issue", r, 1);
    chk("raw_op1", bus.out_op1, 8'hA5);
    chk("raw_rf_we", bus.rf_we, 1);
    chk("raw_rf_addr", bus.rf_wr_addr, 3);
    chk("raw_rf_data", bus.rf_wr_data, 8'hA5);

    // write-buffer bypass over a stale RF entry
    step(1, 1, 0, 0, 4, 1, 1, 0, 0, 0, r);
    step(1, 0, 0, 0, 0, 0, 1, 1, 4, 8'h5C, r);
    step(1, 1, 4, 0, 0, 0, 1, 0, 0, 0, r);
    chk("wbuf_ready", r, 1);
    chk("wbuf_op1", bus.out_op1, 8'h5C);

    // output hold under backpressure
    step(1, 1, 2, 1, 6, 0, 1, 0, 0, 0, r);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, r);
      chk("hold_ready", r, 0);
      chk("hold_op1", bus.out_op1, 8'h22);
      chk("hold_op2", bus.out_op2, 8'h11);
      chk("hold_dst", bus.out_dst, 6);
    end
    step(1, 1, 1, 2, 0, 0, 1, 0, 0, 0, r);
    chk("release_ready", r, 1);
    chk("release_op1", bus.out_op1, 8'h11);

    // WAW and same-cycle set/clear
    step(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, r);
    step(1, 1, 0, 0, 5, 1, 1, 0, 0, 0, r);
    chk("waw_stall", r, 0);
    step(1, 1, 0, 0, 5, 1, 1, 1, 5, 8'h77, r);
    chk("waw_issue", r, 1);
    step(1, 1, 5, 0, 0, 0, 1, 0, 0, 0, r);
    chk("waw_still_pending", r, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1, 5, 8'h78, r);
    step(1, 1, 5, 0, 0, 0, 1, 0, 0, 0, r);
    chk("waw_resolved", r, 1);
    chk("waw_op1", bus.out_op1, 8'h78);
    chk("no_err_yet", bus.wb_err, 0);

    // writeback to a non-pending register
    step(1, 0, 0, 0, 0, 0, 1, 1, 6, 8'h66, r);
    chk("err_set", bus.wb_err, 1);
    chk("err_rf_we", bus.rf_we, 1);
    chk("err_rf_addr", bus.rf_wr_addr, 6);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, r);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, r);
    chk("err_sticky", bus.wb_err, 1);
    chk("err_rf_written", rf_mem[6], 8'h66);

    // reset in the middle of a stall
    step(1, 1, 0, 0, 7, 1, 1, 0, 0, 0, r);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, r);
    chk("mid_stall", r, 0);
    step(0, 1, 7, 0, 0, 0, 0, 0, 0, 0, r);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_err", bus.wb_err, 0);
    step(1, 1, 7, 0, 0, 0, 1, 0, 0, 0, r);
    chk("mid_rst_pend_clear", r, 1);
    chk("mid_rst_op1", bus.out_op1, 8'h77);

    // random traffic, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (!last_wbv && $urandom_range(199) == 0) begin
        step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, r);
        if ($urandom_range(1) == 1) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r);
      end else begin
        rand_step(n >= 2500);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch and writeback stage that acts as the client of the CPU's 8×8 register file. It accepts decoded instructions over a valid/ready handshake and drives the register file's two asynchronous read ports. It forwards the fetched operands to the execute stage through a one-entry output register. Writebacks from execute pass through a one-cycle write buffer that drives the register file's write port; a per-register scoreboard stalls issue on read-after-write (RAW) and write-after-write (WAW) hazards.

## Interface
- REG_WIDTH, 8, data width of every register
- REG_COUNT, 8, number of registers; AW = $clog2(REG_COUNT) (derived, not overridable)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts instruction this cycle
- in_src1 / in_src2  in  AW  source register addresses
- in_dst  in  AW  destination register address
- in_wen  in  1  instruction will write in_dst
- rf_rd_addr1 / rf_rd_addr2  out  AW  register file read addresses
- rf_rd_data1 / rf_rd_data2  in  REG_WIDTH  register file read data (combinational)
- rf_we  out  1  register file write enable
- rf_wr_addr  out  AW  register file write address
- rf_wr_data  out  REG_WIDTH  register file write data
- wb_valid  in  1  execute-stage writeback valid (no backpressure)
- wb_addr  in  AW  writeback register
- wb_data  in  REG_WIDTH  writeback value
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts operands
- out_op1 / out_op2  out  REG_WIDTH  operand values
- out_dst  out  AW  registered in_dst
- out_wen  out  1  registered in_wen
- wb_err  out  1  sticky: writeback to a register that is not pending

## Operation
- rf_rd_addr1 = in_src1 and rf_rd_addr2 = in_src2, both combinational.
- Write buffer:
  - wb_valid is captured into {wbuf_valid, wbuf_addr, wbuf_data} each cycle.
  - rf_we = wbuf_valid, rf_wr_addr = wbuf_addr, rf_wr_data = wbuf_data.
- Operand select, per source, priority high→low:
  - wb_valid with wb_addr == src → wb_data
  - wbuf_valid with wbuf_addr == src → wbuf_data
  - otherwise rf_rd_data.
- Scoreboard: pending[REG_COUNT].
  - Set pending[in_dst] on accept when in_wen.
  - Clear pending[wb_addr] on wb_valid.
  - Set and clear of the same register in the same cycle: set wins.
- clr(r) = wb_valid && wb_addr == r.
- hazard = (pending[in_src1] && !clr(in_src1)) || (pending[in_src2] && !clr(in_src2)) || (in_wen && pending[in_dst] && !clr(in_dst)).
- in_ready = rst_n && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, the output register loads the selected operands, in_dst and in_wen, and out_valid is set to 1.
- Output hold: when out_valid && !out_ready, all out_* fields stay stable.
- When out_ready && !accept, out_valid goes to 0.
- wb_err is set when wb_valid && !pending[wb_addr]. The write is still performed. wb_err clears only on reset.
- Same src1 and src2, or src equal to dst: there is no special case; each field is evaluated independently.

## Timing
- Reset (rst_n = 0 at an edge):
  - out_valid, out_op1, out_op2, out_dst, out_wen, rf_we, rf_wr_addr, rf_wr_data, wb_err all become 0.
  - The scoreboard and write buffer are cleared.
  - in_ready = 0 while rst_n = 0.
- Reset mid-operation discards the held output, all pending bits and any buffered writeback. A writeback presented during reset is lost.
- Issue latency: an instruction accepted at edge N appears on out_* after edge N.
- Full throughput: one instruction per cycle when there are no hazards and out_ready = 1.
- Writeback to register file: wb at edge N reaches rf_we after edge N. The register file updates at edge N+1.
- RAW resolution:
  - A dependent instruction stalls until its producer's wb_valid cycle.
  - It issues in that same cycle using the wb_data bypass.
- All comparisons use AW-bit addresses; no wrap-around arithmetic is involved.

## Test plan
- Reset, then issue src1=1, src2=2 with RF holding r1=0x11, r2=0x22 → out_op1=0x11, out_op2=0x22, out_valid high one cycle after accept; every output is 0 during reset.
- Issue dst=3 with wen=1, then src1=3: in_ready stays 0 until wb_valid with addr=3, data=0xA5. In that same cycle the instruction issues with out_op1=0xA5. rf_we=1, addr 3, data 0xA5 one cycle later.
- Writeback r4=0x5C at edge N, read r4 at edge N+1 → out_op1=0x5C via write-buffer bypass, not the stale RF value.
- Hold out_ready=0 for 3 cycles with out_valid=1 → out_* stable and in_ready=0. Release → next instruction accepted the same cycle.
- Issue dst=5 wen=1, then a second dst=5 wen=1 → second stalls (WAW). Writeback for r5 and re-issue to r5 in the same cycle → pending[5] stays 1.
- wb_valid to a non-pending r6 → wb_err=1 and stays 1; RF write still occurs. Assert rst_n=0 mid-stall → out_valid=0, pending cleared, wb_err=0.
